// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the clock-switch control slice.
package clk_switch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam logic SEL_CLKA = 1'b0;
  localparam logic SEL_CLKB = 1'b1;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_activity_mon.sv
// clkb activity monitor: clkb toggle flop, 3-flop clka synchronizer, edge strobe.
module clk_activity_mon (
  input  logic clka,
  input  logic rst_n,
  input  logic clkb,
  output logic edge_stb
);

  logic       tog;
  logic [2:0] sync;

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) tog <= 1'b0;
    else        tog <= ~tog;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], tog};
  end

  // sync[1] is the second sync stage, sync[2] the edge-detect stage.
  assign edge_stb = sync[1] ^ sync[2];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-switch control FSM: qualifies clkb, drives sel, reports done/err.
// Optional automatic revert to clka on clkb loss: CLK_SWITCH_CTRL_FAILOVER_EN.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned WIN_CYCLES    = 64,
  parameter int unsigned MIN_EDGES     = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic clka,
  input  logic rst_n,
  input  logic clkb,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic clkb_ok
);

  localparam int unsigned WIN_W  = cnt_width(WIN_CYCLES);
  localparam int unsigned EDGE_W = cnt_width(MIN_EDGES + 1);
  localparam int unsigned SET_W  = cnt_width(SETTLE_CYCLES);

  localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(WIN_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(MIN_EDGES);
  localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_e             state, state_n;
  logic               sel_n, ok_n;
  logic [WIN_W-1:0]   win_cnt, win_n;
  logic [EDGE_W-1:0]  edge_cnt, edge_n, edge_inc;
  logic [SET_W-1:0]   settle_cnt, settle_n;
  logic               edge_stb, edge_hit, win_zero, accept, fo_trig;
`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
  logic               fo_flag, fo_n;
`endif

  clk_activity_mon u_mon (
    .clka     (clka),
    .rst_n    (rst_n),
    .clkb     (clkb),
    .edge_stb (edge_stb)
  );

  assign edge_inc = (edge_cnt == EDGE_MAX) ? EDGE_MAX : edge_cnt + EDGE_W'(edge_stb);
  assign edge_hit = (edge_inc == EDGE_MAX);
  assign win_zero = (win_cnt == '0);

`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
  assign fo_trig = (state == IDLE) && (sel == SEL_CLKB) && win_zero && !edge_hit;
`else
  assign fo_trig = 1'b0;
`endif

  assign req_ready = (state == IDLE) && !fo_trig;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= SEL_CLKA;
      clkb_ok    <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      settle_cnt <= '0;
`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
      fo_flag    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      clkb_ok    <= ok_n;
      win_cnt    <= win_n;
      edge_cnt   <= edge_n;
      settle_cnt <= settle_n;
`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
      fo_flag    <= fo_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    ok_n     = clkb_ok;
    win_n    = win_cnt;
    edge_n   = edge_cnt;
    settle_n = settle_cnt;
`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
    fo_n     = fo_flag;
`endif
    unique case (state)
      IDLE: begin
`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
        // Back-to-back monitor windows while running from clkb.
        if (sel == SEL_CLKB) begin
          if (win_zero) begin
            win_n  = WIN_LOAD;
            edge_n = '0;
          end else begin
            win_n  = win_cnt - WIN_W'(1);
            edge_n = edge_inc;
          end
        end
        if (fo_trig) begin
          sel_n    = SEL_CLKA;
          ok_n     = 1'b0;
          fo_n     = 1'b1;
          settle_n = SET_LOAD;
          state_n  = SWITCH;
        end else
`endif
        if (accept) begin
          if (req_sel == sel) begin
            state_n = DONE;
          end else if (req_sel == SEL_CLKA) begin
            sel_n    = SEL_CLKA;
            settle_n = SET_LOAD;
            state_n  = SWITCH;
          end else begin
            win_n   = WIN_LOAD;
            edge_n  = '0;
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        win_n  = win_cnt - WIN_W'(1);
        edge_n = edge_inc;
        // Edge threshold has priority over window expiry in the same cycle.
        if (edge_hit) begin
          ok_n     = 1'b1;
          sel_n    = SEL_CLKB;
          settle_n = SET_LOAD;
          state_n  = SWITCH;
        end else if (win_zero) begin
          ok_n    = 1'b0;
          state_n = ERR;
        end
      end
      SWITCH: begin
        if (settle_cnt == '0) begin
`ifdef CLK_SWITCH_CTRL_FAILOVER_EN
          state_n = fo_flag ? ERR : DONE;
          fo_n    = 1'b0;
`else
          state_n = DONE;
`endif
        end else begin
          settle_n = settle_cnt - SET_W'(1);
        end
      end
      DONE, ERR: begin
        win_n   = WIN_LOAD;
        edge_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Control-side companion of the glitch-free clock switch. It runs on the always-on clock clka and owns the switch's sel input.
- It accepts source-change requests over a valid/ready handshake, then qualifies clkb activity before selecting clkb.
- After every sel change it waits a fixed settle time, then reports done or err.
- With FAILOVER_EN it also reverts to clka automatically when clkb dies.

Parameters:
- WIN_CYCLES, 64: clka cycles in one clkb activity-check window.
- MIN_EDGES, 4: synchronized clkb toggle edges within the window that qualify clkb as alive (1 <= MIN_EDGES < WIN_CYCLES/3).
- SETTLE_CYCLES, 8: clka cycles to hold after sel changes, covering the switch's 2-flop handover in both domains (>= 4).

Ports:
- clka, input, 1: control clock, always running.
- rst_n, input, 1: reset, asynchronous, active-low. Applies to clka-domain and clkb-domain flops alike.
- clkb, input, 1: alternate raw clock, monitored only and never used as data.
- req_valid, input, 1: source-change request.
- req_sel, input, 1: requested source; 0 = clka, 1 = clkb.
- req_ready, output, 1: high only in IDLE.
- sel, output, 1: registered select driven to the clock switch.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a request completes successfully.
- err, output, 1: one-cycle pulse when a request (or failover) fails.
- clkb_ok, output, 1: registered result of the most recent clkb activity check.

Behaviour:
- Reset values: state=IDLE, sel=0, req_ready=1, busy=0, done=0, err=0, clkb_ok=0. All counters are 0 and the clkb toggle flop is 0.
- Reset assertion mid-operation aborts immediately and asynchronously to the reset values. No done/err pulse is produced.
- Activity monitor:
  - A toggle flop in the clkb domain flips on every posedge clkb.
  - Its output passes through 2 clka sync flops plus a third flop for edge detection; an edge is sync2 != sync3.
  - The edge counter saturates at MIN_EDGES.
- The handshake fires when req_valid && req_ready. Requests presented while busy are neither accepted nor queued; the requester must hold req_valid.
- States are IDLE, CHECK, SWITCH, DONE, ERR.
- IDLE, on accept in cycle T:
  - req_sel == sel: go to DONE. done=1 in cycle T+1 and sel is unchanged.
  - req_sel=0, sel=1: sel<=0 at T+1, go to SWITCH.
  - req_sel=1, sel=0: go to CHECK. Load the window counter with WIN_CYCLES-1 and clear the edge count.
- CHECK:
  - Each cycle, decrement the window counter and accumulate edges.
  - When the edge count reaches MIN_EDGES: clkb_ok<=1, sel<=1, go to SWITCH. This exit happens early, without waiting for the window to end.
  - When the window reaches 0 without enough edges: clkb_ok<=0, go to ERR. sel stays 0.
  - The window and edge thresholds are evaluated in the same cycle; if both conditions hold, the edge threshold wins.
- SWITCH: load the settle counter with SETTLE_CYCLES-1 on entry and count down. At 0, go to DONE. The SWITCH state lasts exactly SETTLE_CYCLES cycles.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, then IDLE.
- Latency:
  - To clka: done in cycle T+SETTLE_CYCLES+1.
  - To clkb: done in cycle T+K+SETTLE_CYCLES+1, where K is the CHECK duration (1..WIN_CYCLES).
  - Failed check: err in cycle T+WIN_CYCLES+1.
- sel changes only on the transition into SWITCH, or on failover. It never changes in any other state.

Optional Feature:
- Macro: CLK_SWITCH_CTRL_FAILOVER_EN.
- Defined: while state=IDLE and sel=1, the monitor runs continuous back-to-back windows of WIN_CYCLES. If a window closes with fewer than MIN_EDGES edges:
  - sel<=0 and clkb_ok<=0;
  - go to SWITCH, then to ERR instead of DONE, so err pulses after SETTLE_CYCLES;
  - req_ready stays low during this sequence.
  - A req_valid arriving in the same cycle that failover triggers is not accepted.
- Not defined: no monitoring outside CHECK. sel=1 persists regardless of clkb activity.

Decomposition:
- Shared package/include clk_switch_pkg:
  - state encodings (IDLE=0, CHECK=1, SWITCH=2, DONE=3, ERR=4, 3-bit);
  - SEL_CLKA=0 and SEL_CLKB=1;
  - a counter-width function based on clog2.
- Sub-module clk_activity_mon: holds the clkb toggle flop, the 3-flop synchronizer and the edge detect. Its output is a single edge strobe in clka. It is reused by the failover logic.

Test Plan:
- Reset: check every output against its reset value. Release rst_n with req_valid=0 and confirm sel=0, req_ready=1 for 20 cycles.
- Switch to clkb:
  - Setup: clka 10 ns, clkb 30 ns, default parameters.
  - Stimulus: req_sel=1 accepted at T.
  - Expected: sel=1 within about 30 cycles; done at (sel rise cycle)+8; clkb_ok=1; exactly one done pulse, no err.
- Switch to clkb with clkb held at 0:
  - Stimulus: req_sel=1 accepted at T.
  - Expected: err at T+65; sel stays 0; clkb_ok=0; done never asserts.
- Return to clka:
  - Stimulus: with sel=1, req_sel=0 accepted at T.
  - Expected: sel=0 at T+1; done at T+9; req_ready low in T+1..T+9.
- Same-source request and busy handling:
  - Stimulus: req_sel equal to current sel.
  - Expected: done at T+1, no sel change.
  - Stimulus: request held during busy.
  - Expected: accepted only on return to IDLE.
- Reset during CHECK, plus failover:
  - Stimulus: assert rst_n low mid-window.
  - Expected: immediate IDLE, sel=0, no pulse.
  - Stimulus (FAILOVER_EN defined): sel=1, then stop clkb.
  - Expected: sel=0 within 64+3 cycles; err 8 cycles later.
